// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file (Count, Compare, Status, Cause, EPC, PRId, Config).
// Define CP0_TIMER_INT_EN to implement Compare and the sticky timer interrupt.
module cp0_reg #(
    parameter int INT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [31:0]          wdata_i,
    input  logic [4:0]           raddr_i,
    input  logic [INT_WIDTH-1:0] int_i,
    output logic [31:0]          data_o,
    output logic [31:0]          count_o,
    output logic [31:0]          compare_o,
    output logic [31:0]          status_o,
    output logic [31:0]          cause_o,
    output logic [31:0]          epc_o,
    output logic [31:0]          config_o,
    output logic [31:0]          prid_o,
    output logic                 timer_int_o
);

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;
    localparam logic [4:0] A_CONFIG  = 5'd16;

    localparam logic [31:0] PRID_VAL   = 32'h004C_0102;
    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
    localparam logic [31:0] STATUS_RST = 32'h1000_0000;

    logic [31:0] r_count;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [1:0]  r_cause_ivwp;
    logic [1:0]  r_cause_ip;
    logic [5:0]  r_cause_hw;
    logic [5:0]  w_int;

    assign w_int = 6'(int_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count      <= '0;
            r_status     <= STATUS_RST;
            r_epc        <= '0;
            r_cause_ivwp <= '0;
            r_cause_ip   <= '0;
            r_cause_hw   <= '0;
        end else begin
            r_cause_hw <= w_int;
            // a Count write replaces this cycle's increment
            if (we_i && waddr_i == A_COUNT)
                r_count <= wdata_i;
            else
                r_count <= r_count + 32'd1;
            if (we_i && waddr_i == A_STATUS)
                r_status <= wdata_i;
            if (we_i && waddr_i == A_EPC)
                r_epc <= wdata_i;
            if (we_i && waddr_i == A_CAUSE) begin
                r_cause_ivwp <= wdata_i[23:22];
                r_cause_ip   <= wdata_i[9:8];
            end
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic        w_match;

    assign w_match = (r_compare != '0) && (r_count == r_compare);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else if (we_i && waddr_i == A_COMPARE) begin
            r_compare   <= wdata_i;
            r_timer_int <= 1'b0;
        end else if (w_match) begin
            r_timer_int <= 1'b1;
        end
    end

    assign compare_o   = r_compare;
    assign timer_int_o = r_timer_int;
`else
    assign compare_o   = '0;
    assign timer_int_o = 1'b0;
`endif

    assign count_o  = r_count;
    assign status_o = r_status;
    assign epc_o    = r_epc;
    assign prid_o   = PRID_VAL;
    assign config_o = CONFIG_VAL;
    assign cause_o  = {8'h00, r_cause_ivwp, 6'h00,
                       r_cause_hw, r_cause_ip, 8'h00};

    always_comb begin
        data_o = '0;
        case (raddr_i)
            A_COUNT:   data_o = count_o;
            A_COMPARE: data_o = compare_o;
            A_STATUS:  data_o = status_o;
            A_CAUSE:   data_o = cause_o;
            A_EPC:     data_o = epc_o;
            A_PRID:    data_o = prid_o;
            A_CONFIG:  data_o = config_o;
            default:   data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed stimulus, behavioural CP0 model checked every negedge.
// Timer expectations follow CP0_TIMER_INT_EN as compiled.
module tb_cp0_reg;

`ifdef CP0_TIMER_INT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_o, count_o, compare_o, status_o;
    logic [31:0] cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_reg #(.INT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .raddr_i(raddr_i), .int_i(int_i),
        .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: architectural register values
    logic [31:0] m_count, m_compare, m_status, m_epc, m_cause_sw;
    logic [5:0]  m_hw;
    logic        m_timer;
    wire m_hit = TEN && (m_compare != 0) && (m_count == m_compare);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_count    <= 0;
            m_compare  <= 0;
            m_status   <= 32'h1000_0000;
            m_epc      <= 0;
            m_cause_sw <= 0;
            m_hw       <= 0;
            m_timer    <= 0;
        end else begin
            m_hw <= int_i;
            if (we_i && waddr_i == 9) m_count <= wdata_i;
            else m_count <= m_count + 1;
            if (we_i && waddr_i == 12) m_status <= wdata_i;
            if (we_i && waddr_i == 14) m_epc <= wdata_i;
            if (we_i && waddr_i == 13)
                m_cause_sw <= wdata_i & 32'h00C0_0300;
            if (TEN && we_i && waddr_i == 11) begin
                m_compare <= wdata_i;
                m_timer   <= 0;
            end else if (m_hit) begin
                m_timer <= 1;
            end
        end
    end

    function automatic logic [31:0] m_cause();
        return m_cause_sw | (32'(m_hw) << 10);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            9:       return m_count;
            11:      return m_compare;
            12:      return m_status;
            13:      return m_cause();
            14:      return m_epc;
            15:      return 32'h004C_0102;
            16:      return 32'h0000_8000;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",   count_o,   m_count);
            chk("compare", compare_o, m_compare);
            chk("status",  status_o,  m_status);
            chk("cause",   cause_o,   m_cause());
            chk("epc",     epc_o,     m_epc);
            chk("prid",    prid_o,    32'h004C_0102);
            chk("config",  config_o,  32'h0000_8000);
            chk("timer",   32'(timer_int_o), 32'(m_timer));
            chk("data",    data_o,    m_read(raddr_i));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step(1);
        we_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we_i = 0; waddr_i = 0; wdata_i = 0;
        raddr_i = 0; int_i = 0;
        step(2);
        chk_en = 1'b1;
        chk("rst_count", count_o, 32'h0);
        chk("rst_status", status_o, 32'h1000_0000);
        rst = 1'b1;
        step(10);
        chk("cnt10", count_o, 32'd10);
        chk("status0", status_o, 32'h1000_0000);
        chk("config0", config_o, 32'h0000_8000);
        chk("prid0", prid_o, 32'h004C_0102);

        // wrap
        wr(9, 32'hFFFF_FFFE);
        chk("cnt_ld", count_o, 32'hFFFF_FFFE);
        step(2);
        raddr_i = 9;
        #1;
        chk("cnt_wrap", count_o, 32'h0);
        chk("rd_wrap", data_o, 32'h0);

        // timer match
        wr(11, 32'h20);
        wr(9, 32'h1E);
        chk("tm_e0", 32'(timer_int_o), 32'h0);
        step(2);
        chk("tm_e2", 32'(timer_int_o), 32'h0);
        step(1);
        chk("tm_e3", 32'(timer_int_o), 32'(TEN));
        step(5);
        chk("tm_hold", 32'(timer_int_o), 32'(TEN));
        wr(11, 32'h40);
        chk("tm_clr", 32'(timer_int_o), 32'h0);

        // cause: sw fields and hw lines in one edge
        int_i = 6'b101010;
        wr(13, 32'hFFFF_FFFF);
        chk("cause", cause_o, 32'h00C0_AB00);
        int_i = 6'b000001;
        step(1);
        chk("cause_hw", cause_o, 32'h00C0_0700);

        // read-only and unmapped
        wr(15, 32'h1234_5678);
        wr(20, 32'h1);
        chk("prid_ro", prid_o, 32'h004C_0102);
        raddr_i = 20;
        #1;
        chk("rd20", data_o, 32'h0);
        wr(14, 32'hDEAD_BEEF);
        wr(12, 32'h0000_FF01);
        raddr_i = 14;
        #1;
        chk("rd_epc", data_o, 32'hDEAD_BEEF);
        raddr_i = 12;

        // async reset while timer set
        wr(11, 32'h50);
        wr(9, 32'h4E);
        step(7);
        chk("cnt55", count_o, 32'h55);
        chk("tm55", 32'(timer_int_o), 32'(TEN));
        #2 rst = 1'b0;
        #1;
        chk("arst_tm", 32'(timer_int_o), 32'h0);
        chk("arst_cnt", count_o, 32'h0);
        chk("arst_st", status_o, 32'h1000_0000);
        step(2);
        rst = 1'b1;
        step(4);
        chk("post_cnt", count_o, 32'd4);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
